// File: rtl/aes_pkg.sv
// Shared AES definitions: field polynomial, xtime helper and the InvMixColumns FSM states.
package aes_pkg;

  localparam logic [7:0] AES_POLY = 8'h1B;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? AES_POLY : 8'h00);
  endfunction

endpackage

// File: rtl/inv_mix_columns_seq_if.sv
// Input/output handshake bundle of the sequential InvMixColumns engine.
interface inv_mix_columns_seq_if;
  logic         In_Valid;
  logic         In_Ready;
  logic [127:0] In_Text;
  logic         Out_Valid;
  logic         Out_Ready;
  logic [127:0] Out_Text;

  modport master (
    output In_Valid, In_Text, Out_Ready,
    input  In_Ready, Out_Valid, Out_Text
  );

  modport slave (
    input  In_Valid, In_Text, Out_Ready,
    output In_Ready, Out_Valid, Out_Text
  );
endinterface

// File: rtl/inv_mix_single_column.sv
// Combinational InvMixColumns of one 32-bit column; byte a0 is the MSB byte.
module inv_mix_single_column
  import aes_pkg::*;
(
  input  logic [31:0] col_in,
  output logic [31:0] col_out
);

  logic [7:0] a [4];
  logic [7:0] m09 [4];
  logic [7:0] m0b [4];
  logic [7:0] m0d [4];
  logic [7:0] m0e [4];

  // x2/x4/x8 chain per byte, then the four multiples the matrix needs
  always_comb begin
    for (int unsigned i = 0; i < 4; i++) begin
      logic [7:0] x2, x4, x8;
      a[i]   = col_in[31 - 8*i -: 8];
      x2     = xtime(a[i]);
      x4     = xtime(x2);
      x8     = xtime(x4);
      m09[i] = x8 ^ a[i];
      m0b[i] = x8 ^ x2 ^ a[i];
      m0d[i] = x8 ^ x4 ^ a[i];
      m0e[i] = x8 ^ x4 ^ x2;
    end
  end

  assign col_out[31:24] = m0e[0] ^ m0b[1] ^ m0d[2] ^ m09[3];
  assign col_out[23:16] = m09[0] ^ m0e[1] ^ m0b[2] ^ m0d[3];
  assign col_out[15:8]  = m0d[0] ^ m09[1] ^ m0e[2] ^ m0b[3];
  assign col_out[7:0]   = m0b[0] ^ m0d[1] ^ m09[2] ^ m0e[3];

endmodule

// File: rtl/inv_mix_columns_seq.sv
// Sequential AES InvMixColumns: one column per clock, valid/ready in and out.
module inv_mix_columns_seq
  import aes_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  inv_mix_columns_seq_if.slave   bus
);

  state_t       state;
  logic [1:0]   col;
  logic [127:0] work;
  logic [127:0] work_next;
  logic [127:0] result;
  logic         out_valid;
  logic [31:0]  col_in;
  logic [31:0]  col_out;

  assign bus.In_Ready  = (state == IDLE) | ((state == DONE) & bus.Out_Ready);
  assign bus.Out_Valid = out_valid;
  assign bus.Out_Text  = result;

  always_comb begin
    col_in = '0;
    case (col)
      2'd0: col_in = work[127:96];
      2'd1: col_in = work[95:64];
      2'd2: col_in = work[63:32];
      2'd3: col_in = work[31:0];
      default: col_in = '0;
    endcase
  end

  inv_mix_single_column u_col (
    .col_in  (col_in),
    .col_out (col_out)
  );

  always_comb begin
    work_next = work;
    case (col)
      2'd0: work_next[127:96] = col_out;
      2'd1: work_next[95:64]  = col_out;
      2'd2: work_next[63:32]  = col_out;
      2'd3: work_next[31:0]   = col_out;
      default: work_next = work;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      col       <= '0;
      work      <= '0;
      result    <= '0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.In_Valid) begin
            work  <= bus.In_Text;
            col   <= '0;
            state <= BUSY;
          end
        end
        BUSY: begin
          work <= work_next;
          col  <= col + 2'd1;
          // last column: publish the fully transformed state straight from work_next
          if (col == 2'd3) begin
            result    <= work_next;
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (bus.Out_Ready) begin
            out_valid <= 1'b0;
            if (bus.In_Valid) begin
              work  <= bus.In_Text;
              col   <= '0;
              state <= BUSY;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
